// File: rtl/llc_output_encoder.sv
// llc_output_encoder: transmit-side message buffer for the LLC controller.
// Four independent channels (rsp, fwd, mem, dma). Each channel has its own
// small FIFO that drives a valid/ready interface toward the NoC or memory.
// The controller FSM gets two status signals: out_stall, which gates new
// pushes, and idle, which tells it all queued traffic has drained.

// One channel FIFO. valid and head_data come only from registered state, so
// there is no combinational path from push/push_data to the outputs.
module llc_enc_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     ready,
  output logic                     valid,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_s;
  logic          accept_s;
  logic          drop_s;

  // Handshake decode. A full FIFO still accepts a push when the head leaves
  // on the same edge, because that frees the slot being written.
  always_comb begin
    pop_s    = 1'b0;
    accept_s = 1'b0;
    drop_s   = 1'b0;
    if (count_r != CW'(0)) begin
      pop_s = ready;
    end else begin
      pop_s = 1'b0;
    end
    if (push) begin
      if ((count_r < CW'(DEPTH)) || pop_s) begin
        accept_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
      drop_s   = 1'b0;
    end
  end

  // Pointer and occupancy state. The pointers are log2(DEPTH) bits wide, so
  // they wrap modulo DEPTH on their own. The extra count bit tells full from
  // empty when the two pointers are equal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage. It is cleared on reset so head_data reads zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (accept_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign valid     = (count_r != CW'(0));
  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign drop      = drop_s;

endmodule

// Top level: four channel FIFOs plus the status aggregation.
// DEPTH must be a power of two and at least 2.
module llc_output_encoder #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RSP_W = 64,
  parameter int unsigned FWD_W = 64,
  parameter int unsigned MEM_W = 128,
  parameter int unsigned DMA_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rsp_push,
  input  logic [RSP_W-1:0] rsp_data,
  input  logic             fwd_push,
  input  logic [FWD_W-1:0] fwd_data,
  input  logic             mem_push,
  input  logic [MEM_W-1:0] mem_data,
  input  logic             dma_push,
  input  logic [DMA_W-1:0] dma_data,
  output logic             llc_rsp_out_valid,
  input  logic             llc_rsp_out_ready,
  output logic [RSP_W-1:0] llc_rsp_out_data,
  output logic             llc_fwd_out_valid,
  input  logic             llc_fwd_out_ready,
  output logic [FWD_W-1:0] llc_fwd_out_data,
  output logic             llc_mem_req_valid,
  input  logic             llc_mem_req_ready,
  output logic [MEM_W-1:0] llc_mem_req_data,
  output logic             llc_dma_rsp_out_valid,
  input  logic             llc_dma_rsp_out_ready,
  output logic [DMA_W-1:0] llc_dma_rsp_out_data,
  output logic [3:0]       full,
  output logic             out_stall,
  output logic             idle,
  output logic             overflow_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] rsp_count_s;
  logic [CW-1:0] fwd_count_s;
  logic [CW-1:0] mem_count_s;
  logic [CW-1:0] dma_count_s;
  logic [3:0]    drop_s;
  logic          overflow_err_r;

  llc_enc_fifo #(.DEPTH(DEPTH), .W(RSP_W)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (rsp_data),
    .ready     (llc_rsp_out_ready),
    .valid     (llc_rsp_out_valid),
    .head_data (llc_rsp_out_data),
    .count     (rsp_count_s),
    .drop      (drop_s[0])
  );

  llc_enc_fifo #(.DEPTH(DEPTH), .W(FWD_W)) u_fwd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fwd_push),
    .push_data (fwd_data),
    .ready     (llc_fwd_out_ready),
    .valid     (llc_fwd_out_valid),
    .head_data (llc_fwd_out_data),
    .count     (fwd_count_s),
    .drop      (drop_s[1])
  );

  llc_enc_fifo #(.DEPTH(DEPTH), .W(MEM_W)) u_mem_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_push),
    .push_data (mem_data),
    .ready     (llc_mem_req_ready),
    .valid     (llc_mem_req_valid),
    .head_data (llc_mem_req_data),
    .count     (mem_count_s),
    .drop      (drop_s[2])
  );

  llc_enc_fifo #(.DEPTH(DEPTH), .W(DMA_W)) u_dma_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (dma_push),
    .push_data (dma_data),
    .ready     (llc_dma_rsp_out_ready),
    .valid     (llc_dma_rsp_out_valid),
    .head_data (llc_dma_rsp_out_data),
    .count     (dma_count_s),
    .drop      (drop_s[3])
  );

  // Sticky error flag: any dropped push on any channel sets it until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_err_r <= 1'b0;
    end else if (|drop_s) begin
      overflow_err_r <= 1'b1;
    end
  end

  // full, out_stall and idle are decoded combinationally from the registered
  // counts. That lets the FSM gate pushes in the same cycle the limit is hit.
  assign full = {dma_count_s == CW'(DEPTH),
                 mem_count_s == CW'(DEPTH),
                 fwd_count_s == CW'(DEPTH),
                 rsp_count_s == CW'(DEPTH)};
  assign out_stall    = |full;
  assign idle         = (rsp_count_s == CW'(0)) && (fwd_count_s == CW'(0)) &&
                        (mem_count_s == CW'(0)) && (dma_count_s == CW'(0));
  assign overflow_err = overflow_err_r;

endmodule

// File: tb/tb_llc_output_encoder.sv
// Directed bench for llc_output_encoder. It runs a per-cycle vector table
// first, then hand-written sequences for mid-traffic reset and wrap-around.
module tb_llc_output_encoder;

  logic         clk;
  logic         rst;
  logic         rsp_push, fwd_push, mem_push, dma_push;
  logic [63:0]  rsp_data, fwd_data;
  logic [127:0] mem_data, dma_data;
  logic         rsp_v, fwd_v, mem_v, dma_v;
  logic         rsp_r, fwd_r, mem_r, dma_r;
  logic [63:0]  rsp_q, fwd_q;
  logic [127:0] mem_q, dma_q;
  logic [3:0]   full;
  logic         out_stall, idle, overflow_err;

  int n_cmp = 0;
  int n_err = 0;

  llc_output_encoder dut (
    .clk                   (clk),
    .rst                   (rst),
    .rsp_push              (rsp_push),
    .rsp_data              (rsp_data),
    .fwd_push              (fwd_push),
    .fwd_data              (fwd_data),
    .mem_push              (mem_push),
    .mem_data              (mem_data),
    .dma_push              (dma_push),
    .dma_data              (dma_data),
    .llc_rsp_out_valid     (rsp_v),
    .llc_rsp_out_ready     (rsp_r),
    .llc_rsp_out_data      (rsp_q),
    .llc_fwd_out_valid     (fwd_v),
    .llc_fwd_out_ready     (fwd_r),
    .llc_fwd_out_data      (fwd_q),
    .llc_mem_req_valid     (mem_v),
    .llc_mem_req_ready     (mem_r),
    .llc_mem_req_data      (mem_q),
    .llc_dma_rsp_out_valid (dma_v),
    .llc_dma_rsp_out_ready (dma_r),
    .llc_dma_rsp_out_data  (dma_q),
    .full                  (full),
    .out_stall             (out_stall),
    .idle                  (idle),
    .overflow_err          (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One table row: the inputs applied for a cycle, then the outputs expected
  // just after that cycle's rising edge. Channel bits are {dma,mem,fwd,rsp}.
  typedef struct {
    logic [3:0] push;
    logic [7:0] d;
    logic [3:0] rdy;
    logic [3:0] ev;
    logic [7:0] ersp, efwd, emem, edma;
    logic [3:0] efull;
    logic       eidle;
    logic       eovf;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] push, input logic [7:0] d, input logic [3:0] rdy);
    rsp_push = push[0];
    fwd_push = push[1];
    mem_push = push[2];
    dma_push = push[3];
    rsp_data = 64'(d);
    fwd_data = 64'(d);
    mem_data = 128'(d);
    dma_data = 128'(d);
    rsp_r = rdy[0];
    fwd_r = rdy[1];
    mem_r = rdy[2];
    dma_r = rdy[3];
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 128'({dma_v, mem_v, fwd_v, rsp_v}), 128'(0));
    chk({tag, "_rsp_data"}, 128'(rsp_q), 128'(0));
    chk({tag, "_dma_data"}, dma_q, 128'(0));
    chk({tag, "_full"}, 128'(full), 128'(0));
    chk({tag, "_stall"}, 128'(out_stall), 128'(0));
    chk({tag, "_idle"}, 128'(idle), 128'(1));
    chk({tag, "_ovf"}, 128'(overflow_err), 128'(0));
  endtask

  vec_t vecs[16];

  initial begin
    // Rows 0-1: one-cycle latency on rsp
    vecs[0]  = '{4'b0001, 8'hA5, 4'b1111, 4'b0001, 8'hA5, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{4'b0000, 8'h00, 4'b1111, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1, 1'b0};
    // Rows 2-6: fwd full, then push and pop on the same edge
    vecs[2]  = '{4'b0010, 8'h10, 4'b0000, 4'b0010, 8'h00, 8'h10, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0};
    vecs[3]  = '{4'b0010, 8'h11, 4'b0000, 4'b0010, 8'h00, 8'h10, 8'h00, 8'h00, 4'b0010, 1'b0, 1'b0};
    vecs[4]  = '{4'b0010, 8'h12, 4'b0010, 4'b0010, 8'h00, 8'h11, 8'h00, 8'h00, 4'b0010, 1'b0, 1'b0};
    vecs[5]  = '{4'b0000, 8'h00, 4'b0010, 4'b0010, 8'h00, 8'h12, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{4'b0000, 8'h00, 4'b0010, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1, 1'b0};
    // Rows 7-11: mem back-pressure and a dropped push
    vecs[7]  = '{4'b0100, 8'h01, 4'b0000, 4'b0100, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0000, 1'b0, 1'b0};
    vecs[8]  = '{4'b0100, 8'h02, 4'b0000, 4'b0100, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0100, 1'b0, 1'b0};
    vecs[9]  = '{4'b0100, 8'h03, 4'b0000, 4'b0100, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0100, 1'b0, 1'b1};
    vecs[10] = '{4'b0000, 8'h00, 4'b0100, 4'b0100, 8'h00, 8'h00, 8'h02, 8'h00, 4'b0000, 1'b0, 1'b1};
    vecs[11] = '{4'b0000, 8'h00, 4'b0100, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1, 1'b1};
    // Rows 12-15: all channels push together, only rsp ready at first
    vecs[12] = '{4'b1111, 8'h5A, 4'b0001, 4'b1111, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 4'b0000, 1'b0, 1'b1};
    vecs[13] = '{4'b0000, 8'h00, 4'b0001, 4'b1110, 8'h00, 8'h5A, 8'h5A, 8'h5A, 4'b0000, 1'b0, 1'b1};
    vecs[14] = '{4'b0000, 8'h00, 4'b0001, 4'b1110, 8'h00, 8'h5A, 8'h5A, 8'h5A, 4'b0000, 1'b0, 1'b1};
    vecs[15] = '{4'b0000, 8'h00, 4'b1110, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1, 1'b1};

    drive(4'b0000, 8'h00, 4'b0000);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].push, vecs[i].d, vecs[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 128'({dma_v, mem_v, fwd_v, rsp_v}), 128'(vecs[i].ev));
      if (vecs[i].ev[0]) chk($sformatf("v%0d_rsp_data", i), 128'(rsp_q), 128'(vecs[i].ersp));
      if (vecs[i].ev[1]) chk($sformatf("v%0d_fwd_data", i), 128'(fwd_q), 128'(vecs[i].efwd));
      if (vecs[i].ev[2]) chk($sformatf("v%0d_mem_data", i), mem_q, 128'(vecs[i].emem));
      if (vecs[i].ev[3]) chk($sformatf("v%0d_dma_data", i), dma_q, 128'(vecs[i].edma));
      chk($sformatf("v%0d_full", i), 128'(full), 128'(vecs[i].efull));
      chk($sformatf("v%0d_stall", i), 128'(out_stall), 128'(|vecs[i].efull));
      chk($sformatf("v%0d_idle", i), 128'(idle), 128'(vecs[i].eidle));
      chk($sformatf("v%0d_ovf", i), 128'(overflow_err), 128'(vecs[i].eovf));
    end

    // Reset in the middle of traffic: rsp holds two entries when reset hits
    drive(4'b0001, 8'h77, 4'b0000);
    @(posedge clk);
    drive(4'b0001, 8'h78, 4'b0000);
    @(posedge clk);
    #1;
    drive(4'b0000, 8'h00, 4'b0000);
    chk("pre_reset_rsp_full", 128'(full[0]), 128'(1));
    #2;
    rst = 1'b0;
    #1;
    chk_reset_state("async_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0000, 8'h00, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_reset_valid%0d", k), 128'({dma_v, mem_v, fwd_v, rsp_v}), 128'(0));
      chk($sformatf("post_reset_idle%0d", k), 128'(idle), 128'(1));
    end

    // Wrap-around on dma: push a value every other cycle while ready toggles
    begin
      int nxt_push;
      int nxt_exp;
      nxt_push = 0;
      nxt_exp = 0;
      for (int c = 0; c < 26; c++) begin
        logic do_push;
        logic rdy_now;
        do_push = ((c % 2) == 0) && (nxt_push < 10);
        rdy_now = ((c % 2) == 0);
        drive({do_push, 3'b000}, 8'(nxt_push), {rdy_now, 3'b000});
        if (dma_v && rdy_now) begin
          chk($sformatf("wrap_pop%0d", nxt_exp), dma_q, 128'(nxt_exp));
          nxt_exp++;
        end
        if (do_push) nxt_push++;
        @(posedge clk);
        #1;
      end
      chk("wrap_count", 128'(nxt_exp), 128'(10));
      chk("wrap_ovf", 128'(overflow_err), 128'(0));
      chk("wrap_idle", 128'(idle), 128'(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
